line_follow_ctrl: RTL and testbench
===================================

Name: line_follow_ctrl

Overview:
- Parametrised successor to the forward-motion decision block.
- Turns an N-wide line-sensor array, the front obstacle IR and the move/direction commands into the 4-bit H-bridge IN1..IN4 code for the routing module.
- Adds over the previous generation: a debounced sensor pattern, a general left/right rule for any even sensor count, a lost-line search with timeout, an obstacle release hysteresis and a state output for debug LEDs.

Parameters:
- N_SENS, 4: number of line sensors; even, at least 2. Index N_SENS-1 is the leftmost sensor.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles before a sensor pattern is accepted. The same count applies to obstacle release.
- LOST_TIMEOUT, 50000000: cycles spent searching after the line is lost before latching a stop.
- CNT_W, 28: counter width; must hold max(DEBOUNCE_CYCLES, LOST_TIMEOUT).

Ports:
- clock, input, 1: system clock; all logic on posedge.
- reset, input, 1: asynchronous, active-high; clears all state.
- can_move, input, 1: 1 = motion permitted; 0 = waiting for the audio command.
- dir_forward, input, 1: 1 = line-follow forward; 0 = reverse/hold orientation.
- obstacle_n, input, 1: front IR; 0 = vehicle detected.
- sens_line, input, N_SENS: raw line-sensor bits; 1 = line seen.
- present_ins, input, 4: current IN1..IN4 code, passed through in reverse mode.
- hbridge_ins, output, 4: registered IN1..IN4 code to the routing module.
- moving_forward, output, 1: 1 while in FOLLOW or SEARCH.
- state_out, output, 3: encoded current state.
- lost_latched, output, 1: 1 while in LOST_STOP.

Behaviour:
- Codes:
  - INERTIAL_STOP = 0000
  - HARD_STOP = 1111
  - FORWARD = 0110
  - TURN_RIGHT = 0101
  - TURN_LEFT = 1010
- Reset values: hbridge_ins = 0000, moving_forward = 0, lost_latched = 0, state = IDLE, filtered pattern = 0, all counters = 0.
- Sensor filter:
  - A candidate pattern is captured whenever sens_line differs from the previous raw sample, and the stability counter restarts.
  - Once the candidate has been stable for DEBOUNCE_CYCLES consecutive cycles, it is copied to filt_line.
  - The counter saturates; it does not wrap.
- Direction rule, evaluated on filt_line:
  - L = popcount of the upper half; R = popcount of the lower half.
  - All zero: no line.
  - All ones: hold the previous command (line crossing).
  - R > L: TURN_RIGHT.
  - L > R: TURN_LEFT.
  - L == R and nonzero: FORWARD.
- Obstacle:
  - obstacle_n = 0 forces state OBSTACLE and hbridge_ins = 1111 at the next posedge (1-cycle latency). No debounce is applied on assertion.
  - Leaving OBSTACLE requires obstacle_n = 1 for DEBOUNCE_CYCLES consecutive cycles.
  - After release, the next state follows the normal transition rules, evaluated from IDLE.
- State priority, highest first: reset > obstacle > can_move = 0 > LOST_STOP latch > dir_forward.
- States (encoding 0..5):
  - IDLE: hbridge_ins = 0000. If can_move = 1, go to FOLLOW when dir_forward = 1, or to REVERSE when dir_forward = 0.
  - FOLLOW: hbridge_ins = direction-rule output, registered. If filt_line is all zero, go to SEARCH and load the lost counter with 0. If dir_forward = 0, go to REVERSE.
  - SEARCH: hbridge_ins holds the last turn or forward command issued in FOLLOW, and the lost counter increments.
    - If any filt_line bit is 1, return to FOLLOW; the counter is cleared.
    - When the counter reaches LOST_TIMEOUT-1, go to LOST_STOP.
  - LOST_STOP: hbridge_ins = 0000, lost_latched = 1. Exit only through can_move = 0, which goes to IDLE, or through reset.
  - REVERSE: hbridge_ins = present_ins, sampled every cycle. If dir_forward = 1, go to FOLLOW.
  - OBSTACLE: hbridge_ins = 1111.
- can_move = 0 in any non-OBSTACLE state: IDLE on the next posedge, with 0000 output in that same cycle. The SEARCH counter is cleared.
- Simultaneous events: obstacle wins over a lost timeout in the same cycle. A line reappearing in the cycle the timeout expires returns to FOLLOW.
- Reset mid-SEARCH or mid-debounce: all counters cleared immediately; outputs take their reset values asynchronously.

Decomposition:
- Package line_follow_pkg:
  - the H-bridge code constants;
  - the state enum/localparams;
  - a popcount function.
- One sub-module, line_filter, parametrised on N_SENS, DEBOUNCE_CYCLES and CNT_W.
  - Ports: clock, reset, raw, filt, filt_valid.
  - Instantiated once for sens_line.
  - The obstacle release counter stays in the top module.

Test Plan (N_SENS = 4, DEBOUNCE_CYCLES = 4, LOST_TIMEOUT = 8):
- Reset released, can_move = 1, dir_forward = 1, sens_line = 0110 held → state FOLLOW; hbridge_ins = 0110 no later than 6 cycles after sens_line settles.
- In FOLLOW, sens_line = 0011 for 2 cycles, then back to 0110 → glitch rejected, hbridge_ins stays 0110. Then 0011 held for 4 cycles → 0101. Then 1110 held → 1010.
- In FOLLOW, sens_line = 0000 held → SEARCH holding the last code for 8 cycles, then LOST_STOP with 0000 and lost_latched = 1. Toggling can_move 1→0→1 → IDLE, then FOLLOW.
- obstacle_n pulsed 0 for 1 cycle in FOLLOW → 1111 on the next posedge; 1111 held until 4 clear cycles; then FOLLOW resumes. obstacle_n low at the exact SEARCH timeout cycle → OBSTACLE, not LOST_STOP.
- dir_forward = 0, present_ins = 1001, then present_ins = 0101 → hbridge_ins tracks with 1-cycle latency; moving_forward = 0.
- Reset asserted mid-SEARCH (counter = 5) → hbridge_ins = 0000 and state IDLE immediately, without waiting for a clock edge. After release, the full 8-cycle timeout is required again.

Source files
------------

// File: rtl/line_follow_pkg.sv
// Shared constants for the line-follow controller: H-bridge codes, state
// encoding and a small popcount helper.
package line_follow_pkg;

    localparam logic [3:0] INERTIAL_STOP = 4'b0000;
    localparam logic [3:0] HARD_STOP     = 4'b1111;
    localparam logic [3:0] FORWARD       = 4'b0110;
    localparam logic [3:0] TURN_RIGHT    = 4'b0101;
    localparam logic [3:0] TURN_LEFT     = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FOLLOW    = 3'd1,
        ST_SEARCH    = 3'd2,
        ST_LOST_STOP = 3'd3,
        ST_REVERSE   = 3'd4,
        ST_OBSTACLE  = 3'd5
    } ctrlState_e;

    // Callers zero-extend their half-array into the 32-bit argument.
    function automatic logic [5:0] popCount(input logic [31:0] bits);
        logic [5:0] total;
        total = '0;
        for (int i = 0; i < 32; i++) begin
            total = total + 6'(bits[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/line_filter.sv
// Debounces the raw line-sensor pattern: a pattern is accepted once it has been
// sampled unchanged on DEBOUNCE_CYCLES consecutive clock edges.
module line_filter #(
    parameter int N_SENS          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 28
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_SENS-1:0] raw,
    output logic [N_SENS-1:0] filt,
    output logic              filt_valid
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [N_SENS-1:0] rawPrev;
    logic [CNT_W-1:0]  stableCnt;
    logic [CNT_W-1:0]  stableCntNext;

    // The sample that differs from its predecessor is the first of a new run.
    always_comb begin
        stableCntNext = stableCnt;
        if (raw != rawPrev) begin
            stableCntNext = CNT_W'(1);
        end else if (stableCnt < STABLE_MAX) begin
            stableCntNext = stableCnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rawPrev    <= '0;
            stableCnt  <= '0;
            filt       <= '0;
            filt_valid <= 1'b0;
        end else begin
            rawPrev   <= raw;
            stableCnt <= stableCntNext;
            if (stableCntNext >= STABLE_MAX) begin
                filt       <= raw;
                filt_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_follow_ctrl.sv
// Forward-motion decision block: debounced line following with lost-line
// search, obstacle hard stop with release hysteresis, and reverse pass-through.
module line_follow_ctrl #(
    parameter int N_SENS          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOST_TIMEOUT    = 50000000,
    parameter int CNT_W           = 28
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              can_move,
    input  logic              dir_forward,
    input  logic              obstacle_n,
    input  logic [N_SENS-1:0] sens_line,
    input  logic [3:0]        present_ins,
    output logic [3:0]        hbridge_ins,
    output logic              moving_forward,
    output logic [2:0]        state_out,
    output logic              lost_latched
);

    import line_follow_pkg::*;

    localparam logic [CNT_W-1:0] LOST_LAST   = CNT_W'(LOST_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RELEASE_MAX = CNT_W'(DEBOUNCE_CYCLES);

    ctrlState_e        state;
    ctrlState_e        nextState;
    logic [N_SENS-1:0] filtLine;
    logic              filtValid;
    logic [3:0]        lastCmd;
    logic [3:0]        ruleCmd;
    logic [CNT_W-1:0]  lostCnt;
    logic [CNT_W-1:0]  lostCntNext;
    logic [CNT_W-1:0]  releaseCnt;
    logic [CNT_W-1:0]  releaseCntNext;
    logic [5:0]        leftCnt;
    logic [5:0]        rightCnt;

    line_filter #(
        .N_SENS          (N_SENS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) sensFilter (
        .clock      (clock),
        .reset      (reset),
        .raw        (sens_line),
        .filt       (filtLine),
        .filt_valid (filtValid)
    );

    // Steering: compare sensor counts on the left and right halves.
    always_comb begin
        leftCnt  = popCount(32'(filtLine[N_SENS-1:N_SENS/2]));
        rightCnt = popCount(32'(filtLine[N_SENS/2-1:0]));
        ruleCmd  = lastCmd;
        if (filtLine == '0 || filtLine == '1) begin
            ruleCmd = lastCmd;
        end else if (rightCnt > leftCnt) begin
            ruleCmd = TURN_RIGHT;
        end else if (leftCnt > rightCnt) begin
            ruleCmd = TURN_LEFT;
        end else begin
            ruleCmd = FORWARD;
        end
    end

    always_comb begin
        nextState      = state;
        lostCntNext    = lostCnt;
        releaseCntNext = releaseCnt;
        if (!obstacle_n) begin
            nextState      = ST_OBSTACLE;
            releaseCntNext = '0;
            lostCntNext    = '0;
        end else if (state == ST_OBSTACLE) begin
            // Release re-enters the normal rules as though starting from IDLE.
            if (releaseCnt + CNT_W'(1) >= RELEASE_MAX) begin
                releaseCntNext = '0;
                if (!can_move) begin
                    nextState = ST_IDLE;
                end else begin
                    nextState = dir_forward ? ST_FOLLOW : ST_REVERSE;
                end
            end else begin
                releaseCntNext = releaseCnt + CNT_W'(1);
            end
        end else if (!can_move) begin
            nextState   = ST_IDLE;
            lostCntNext = '0;
        end else begin
            case (state)
                ST_IDLE: nextState = dir_forward ? ST_FOLLOW : ST_REVERSE;
                ST_FOLLOW: begin
                    // No lost-line decision before the first accepted pattern.
                    if (filtValid && filtLine == '0) begin
                        nextState   = ST_SEARCH;
                        lostCntNext = '0;
                    end else if (!dir_forward) begin
                        nextState = ST_REVERSE;
                    end
                end
                ST_SEARCH: begin
                    if (filtLine != '0) begin
                        nextState   = ST_FOLLOW;
                        lostCntNext = '0;
                    end else if (lostCnt == LOST_LAST) begin
                        nextState   = ST_LOST_STOP;
                        lostCntNext = '0;
                    end else begin
                        lostCntNext = lostCnt + CNT_W'(1);
                    end
                end
                ST_LOST_STOP: nextState = ST_LOST_STOP;
                ST_REVERSE: begin
                    if (dir_forward) begin
                        nextState = ST_FOLLOW;
                    end
                end
                default: nextState = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered for the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            hbridge_ins    <= INERTIAL_STOP;
            moving_forward <= 1'b0;
            lost_latched   <= 1'b0;
            lastCmd        <= INERTIAL_STOP;
            lostCnt        <= '0;
            releaseCnt     <= '0;
        end else begin
            state          <= nextState;
            lostCnt        <= lostCntNext;
            releaseCnt     <= releaseCntNext;
            moving_forward <= (nextState == ST_FOLLOW) || (nextState == ST_SEARCH);
            lost_latched   <= (nextState == ST_LOST_STOP);
            case (nextState)
                ST_FOLLOW: begin
                    hbridge_ins <= ruleCmd;
                    lastCmd     <= ruleCmd;
                end
                ST_SEARCH:   hbridge_ins <= lastCmd;
                ST_REVERSE:  hbridge_ins <= present_ins;
                ST_OBSTACLE: hbridge_ins <= HARD_STOP;
                default:     hbridge_ins <= INERTIAL_STOP;
            endcase
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Randomized bench for line_follow_ctrl with a behavioural reference model,
// plus directed scenarios pinned by hand-computed expectations.
module tb_line_follow_ctrl;

    localparam int NS  = 4;
    localparam int DEB = 4;
    localparam int LT  = 8;
    localparam int CW  = 8;

    localparam logic [3:0] C_STOP  = 4'b0000;
    localparam logic [3:0] C_HARD  = 4'b1111;
    localparam logic [3:0] C_FWD   = 4'b0110;
    localparam logic [3:0] C_RIGHT = 4'b0101;
    localparam logic [3:0] C_LEFT  = 4'b1010;

    localparam int S_IDLE = 0, S_FOLLOW = 1, S_SEARCH = 2, S_LOST = 3, S_REV = 4, S_OBS = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          can_move = 1'b1;
    logic          dir_forward = 1'b1;
    logic          obstacle_n = 1'b1;
    logic [NS-1:0] sens_line = '0;
    logic [3:0]    present_ins = '0;
    logic [3:0]    hbridge_ins;
    logic          moving_forward;
    logic [2:0]    state_out;
    logic          lost_latched;

    int compared = 0;
    int mismatched = 0;
    bit checkEn = 1'b0;

    // Reference model state
    int            mState;
    logic [3:0]    mOut;
    logic [3:0]    mLastCmd;
    int            mRun;
    bit            mHave;
    logic [NS-1:0] mPrevSample;
    logic [NS-1:0] mFilt;
    bit            mValid;
    int            mSearch;
    int            mClear;

    line_follow_ctrl #(
        .N_SENS          (NS),
        .DEBOUNCE_CYCLES (DEB),
        .LOST_TIMEOUT    (LT),
        .CNT_W           (CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .can_move       (can_move),
        .dir_forward    (dir_forward),
        .obstacle_n     (obstacle_n),
        .sens_line      (sens_line),
        .present_ins    (present_ins),
        .hbridge_ins    (hbridge_ins),
        .moving_forward (moving_forward),
        .state_out      (state_out),
        .lost_latched   (lost_latched)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
        end
    endtask

    function automatic logic [3:0] dirRule(input logic [NS-1:0] f, input logic [3:0] prev);
        int l = 0;
        int r = 0;
        for (int i = 0; i < NS; i++) begin
            if (f[i]) begin
                if (i >= NS / 2) l++;
                else r++;
            end
        end
        if (l + r == 0 || l + r == NS) return prev;
        if (r > l) return C_RIGHT;
        if (l > r) return C_LEFT;
        return C_FWD;
    endfunction

    task automatic modelReset();
        mState = S_IDLE; mOut = C_STOP; mLastCmd = C_STOP;
        mRun = 0; mHave = 0; mPrevSample = '0; mFilt = '0; mValid = 0;
        mSearch = 0; mClear = 0;
    endtask

    // One clock edge of the reference: decisions use the pattern accepted so far,
    // then the current sensor sample is folded into the debounce history.
    task automatic modelStep();
        logic [NS-1:0] f;
        bit v;
        if (reset) begin
            modelReset();
            return;
        end
        f = mFilt;
        v = mValid;
        if (!obstacle_n) begin
            mState = S_OBS;
            mClear = 0;
        end else if (mState == S_OBS) begin
            mClear++;
            if (mClear >= DEB) begin
                mClear = 0;
                mState = !can_move ? S_IDLE : (dir_forward ? S_FOLLOW : S_REV);
            end
        end else if (!can_move) begin
            mState = S_IDLE;
        end else if (mState == S_IDLE) begin
            mState = dir_forward ? S_FOLLOW : S_REV;
        end else if (mState == S_FOLLOW) begin
            if (v && f == '0) begin
                mState = S_SEARCH;
                mSearch = 0;
            end else if (!dir_forward) begin
                mState = S_REV;
            end
        end else if (mState == S_SEARCH) begin
            if (f != '0) begin
                mState = S_FOLLOW;
            end else begin
                mSearch++;
                if (mSearch == LT) mState = S_LOST;
            end
        end else if (mState == S_REV) begin
            if (dir_forward) mState = S_FOLLOW;
        end

        case (mState)
            S_FOLLOW: begin
                mOut = dirRule(f, mLastCmd);
                mLastCmd = mOut;
            end
            S_SEARCH: mOut = mLastCmd;
            S_REV:    mOut = present_ins;
            S_OBS:    mOut = C_HARD;
            default:  mOut = C_STOP;
        endcase

        if (mHave && sens_line == mPrevSample) begin
            if (mRun < DEB) mRun++;
        end else begin
            mRun = 1;
        end
        mHave = 1;
        mPrevSample = sens_line;
        if (mRun >= DEB) begin
            mFilt = sens_line;
            mValid = 1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            modelStep();
        end
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases after an edge.
    task automatic midCycleReset();
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        check("async_reset_hbridge", hbridge_ins, C_STOP);
        check("async_reset_state", state_out, S_IDLE);
        @(posedge clock);
        #1;
        modelStep();
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        if (checkEn) begin
            check("hbridge_ins", hbridge_ins, mOut);
            check("state_out", state_out, mState);
            check("moving_forward", moving_forward, (mState == S_FOLLOW || mState == S_SEARCH));
            check("lost_latched", lost_latched, (mState == S_LOST));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pick;
        modelReset();
        sens_line = 4'b0110;
        repeat (2) @(posedge clock);
        #1;
        check("reset_hbridge", hbridge_ins, C_STOP);
        check("reset_state", state_out, S_IDLE);
        check("reset_lost", lost_latched, 1'b0);
        check("reset_moving", moving_forward, 1'b0);
        reset = 1'b0;
        checkEn = 1'b1;

        // Line acquisition and steering
        tick(6);
        check("acquire_state", state_out, S_FOLLOW);
        check("acquire_code", hbridge_ins, C_FWD);
        sens_line = 4'b0011; tick(2);
        sens_line = 4'b0110; tick(6);
        check("glitch_rejected", hbridge_ins, C_FWD);
        sens_line = 4'b0011; tick(6);
        check("turn_right", hbridge_ins, C_RIGHT);
        sens_line = 4'b1110; tick(6);
        check("turn_left", hbridge_ins, C_LEFT);

        // Lost line: search then latch
        sens_line = 4'b0000; tick(5);
        check("search_entered", state_out, S_SEARCH);
        check("search_holds", hbridge_ins, C_LEFT);
        tick(7);
        check("search_last_cycle", state_out, S_SEARCH);
        tick(1);
        check("lost_state", state_out, S_LOST);
        check("lost_code", hbridge_ins, C_STOP);
        check("lost_flag", lost_latched, 1'b1);
        sens_line = 4'b0110; tick(5);
        can_move = 1'b0; tick(1);
        check("unlatch_idle", state_out, S_IDLE);
        can_move = 1'b1; tick(1);
        check("refollow_state", state_out, S_FOLLOW);
        check("refollow_code", hbridge_ins, C_FWD);

        // Obstacle pulse and release hysteresis
        obstacle_n = 1'b0; tick(1);
        check("obstacle_state", state_out, S_OBS);
        check("obstacle_code", hbridge_ins, C_HARD);
        obstacle_n = 1'b1; tick(3);
        check("obstacle_held", hbridge_ins, C_HARD);
        tick(1);
        check("obstacle_release", state_out, S_FOLLOW);
        check("obstacle_release_code", hbridge_ins, C_FWD);

        // Obstacle coinciding with the search timeout
        sens_line = 4'b0000; tick(5);
        tick(7);
        obstacle_n = 1'b0; tick(1);
        check("obstacle_beats_timeout", state_out, S_OBS);
        obstacle_n = 1'b1; sens_line = 4'b0110; tick(6);
        check("post_obstacle_follow", state_out, S_FOLLOW);

        // Reverse pass-through
        dir_forward = 1'b0; present_ins = 4'b1001; tick(1);
        check("reverse_state", state_out, S_REV);
        check("reverse_code1", hbridge_ins, 4'b1001);
        check("reverse_moving", moving_forward, 1'b0);
        present_ins = 4'b0101; tick(1);
        check("reverse_code2", hbridge_ins, 4'b0101);

        // Reset in the middle of a search restarts the full timeout
        dir_forward = 1'b1; tick(1);
        sens_line = 4'b0000; tick(5);
        tick(5);
        midCycleReset();
        tick(12);
        check("timeout_restart_search", state_out, S_SEARCH);
        tick(1);
        check("timeout_restart_lost", state_out, S_LOST);

        // Randomized phase against the reference model
        for (int k = 0; k < 3000; k++) begin
            obstacle_n = ($urandom_range(0, 39) != 0);
            can_move = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 49) == 0) dir_forward = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                pick = $urandom_range(0, 5);
                if (pick == 0) sens_line = '0;
                else if (pick == 1) sens_line = '1;
                else sens_line = NS'($urandom);
            end
            present_ins = 4'($urandom);
            if ($urandom_range(0, 799) == 0) midCycleReset();
            else tick(1);
        end

        tick(1);
        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
